// File: rtl/perf_pkg.sv
// Shared constants for the run-control / performance monitor: state encoding,
// default widths and the end-of-program address used by benches.
package perf_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] TOUT = 2'd3;

    localparam int DEF_WIDTH_I = 32;
    localparam int DEF_CNT_W   = 32;
    localparam int DEF_N_EVT   = 4;

    localparam logic [31:0] END_ADDR = 32'h0000_0080;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module perf_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && !(&cnt_o)) begin
            cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/perf_monitor.sv
// Run-control monitor: counts cycles and event strobes from arm until the
// observed PC hits end_addr, or until the programmable timeout expires.
module perf_monitor
    import perf_pkg::*;
#(
    parameter int WIDTH_I = DEF_WIDTH_I,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int N_EVT   = DEF_N_EVT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH_I-1:0]     addr_in,
    input  logic [WIDTH_I-1:0]     end_addr,
    input  logic [CNT_W-1:0]       timeout_lim,
    input  logic [N_EVT-1:0]       evt_in,
    input  logic                   arm,
    input  logic                   clr,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [N_EVT*CNT_W-1:0] evt_cnt,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [1:0]             dbg_state
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             match;
    logic             run_inc;
    logic             clr_cnt;
    logic [CNT_W-1:0] cyc_next;

    assign match    = (addr_in == end_addr);
    assign cyc_next = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);

    // Counters only advance on RUN edges that neither abort nor match.
    assign run_inc = (state_q == RUN) && !clr && !match;
    // clr zeroes in every state; arm zeroes whenever it (re)starts a run.
    assign clr_cnt = clr || (arm && (state_q != RUN));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!clr && arm) state_d = RUN;
            end
            RUN: begin
                if (clr) begin
                    state_d = IDLE;
                end else if (match) begin
                    state_d = DONE;
                end else if ((timeout_lim != '0) && (cyc_next == timeout_lim)) begin
                    state_d = TOUT;
                end
            end
            default: begin
                if (clr) begin
                    state_d = IDLE;
                end else if (arm) begin
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    perf_sat_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_cnt),
        .inc_i (run_inc),
        .cnt_o (cycle_cnt)
    );

    for (genvar k = 0; k < N_EVT; k++) begin : g_evt
        perf_sat_counter #(.CNT_W(CNT_W)) u_evt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (clr_cnt),
            .inc_i (run_inc && evt_in[k]),
            .cnt_o (evt_cnt[k*CNT_W +: CNT_W])
        );
    end

    // Status flags come straight from the state register.
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign timeout   = (state_q == TOUT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a default-size instance for run control and
// a CNT_W=4 / N_EVT=2 instance for counter saturation.
module tb_perf_monitor;
    import perf_pkg::*;

    logic         clk;
    logic         rst_n;

    logic [31:0]  addr_in, end_addr, timeout_lim;
    logic [3:0]   evt_in;
    logic         arm, clr;
    logic [31:0]  cycle_cnt;
    logic [127:0] evt_cnt;
    logic         busy, done, timeout;
    logic [1:0]   dbg_state;

    logic [31:0]  s_addr, s_end;
    logic [3:0]   s_tl;
    logic [1:0]   s_evt;
    logic         s_arm, s_clr;
    logic [3:0]   s_cyc;
    logic [7:0]   s_evt_cnt;
    logic         s_busy, s_done, s_timeout;
    logic [1:0]   s_state;

    int n_checks = 0;
    int n_pass   = 0;

    perf_monitor dut (
        .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .end_addr(end_addr),
        .timeout_lim(timeout_lim), .evt_in(evt_in), .arm(arm), .clr(clr),
        .cycle_cnt(cycle_cnt), .evt_cnt(evt_cnt), .busy(busy), .done(done),
        .timeout(timeout), .dbg_state(dbg_state)
    );

    perf_monitor #(.WIDTH_I(32), .CNT_W(4), .N_EVT(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .addr_in(s_addr), .end_addr(s_end),
        .timeout_lim(s_tl), .evt_in(s_evt), .arm(s_arm), .clr(s_clr),
        .cycle_cnt(s_cyc), .evt_cnt(s_evt_cnt), .busy(s_busy), .done(s_done),
        .timeout(s_timeout), .dbg_state(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm_once();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; clr = 1'b0; addr_in = '0;
        end_addr = END_ADDR; timeout_lim = '0; evt_in = '0;
        s_addr = 32'h10; s_end = END_ADDR; s_tl = '0; s_evt = '0;
        s_arm = 1'b0; s_clr = 1'b0;
        tick(2);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cyc", cycle_cnt, 0);
        check("rst_evt", evt_cnt, 0);
        rst_n = 1'b1;
        tick(3);
        check("idle_state", dbg_state, IDLE);

        // Nominal run: 32 PCs before the end address, evt_in follows i[3:0].
        arm_once();
        check("arm_busy", busy, 1'b1);
        check("arm_cyc", cycle_cnt, 0);
        for (int i = 0; i < 32; i++) begin
            addr_in = 32'(i * 4);
            evt_in  = 4'(i);
            tick(1);
        end
        check("run_cyc32", cycle_cnt, 32);
        check("run_busy", busy, 1'b1);
        addr_in = END_ADDR; evt_in = 4'hf;
        tick(1);
        check("nom_done", done, 1'b1);
        check("nom_busy", busy, 1'b0);
        check("nom_tout", timeout, 1'b0);
        check("nom_cyc", cycle_cnt, 32);
        check("nom_evt", evt_cnt, {32'd16, 32'd16, 32'd16, 32'd16});
        addr_in = 32'h10;
        tick(5);
        check("hold_done", done, 1'b1);
        check("hold_cyc", cycle_cnt, 32);
        check("hold_evt", evt_cnt, {32'd16, 32'd16, 32'd16, 32'd16});
        evt_in = '0;

        // arm and clr together in DONE: clr wins.
        arm = 1'b1; clr = 1'b1;
        tick(1);
        arm = 1'b0; clr = 1'b0;
        check("armclr_state", dbg_state, IDLE);
        check("armclr_cyc", cycle_cnt, 0);
        check("armclr_evt", evt_cnt, 0);

        // Timeout after 10 counted edges.
        timeout_lim = 10; addr_in = 32'h10;
        arm_once();
        tick(9);
        check("to_pre_cyc", cycle_cnt, 9);
        check("to_pre_flag", timeout, 1'b0);
        tick(1);
        check("to_flag", timeout, 1'b1);
        check("to_cyc", cycle_cnt, 10);
        check("to_done", done, 1'b0);
        check("to_busy", busy, 1'b0);
        tick(3);
        check("to_hold", cycle_cnt, 10);

        // Re-arm from TOUT restarts counting.
        timeout_lim = 0;
        arm_once();
        check("rearm_busy", busy, 1'b1);
        check("rearm_cyc", cycle_cnt, 0);
        tick(3);
        check("rearm_cyc3", cycle_cnt, 3);
        arm_once();
        check("arm_in_run", cycle_cnt, 4);
        tick(2);
        check("arm_in_run2", cycle_cnt, 6);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_state", dbg_state, IDLE);
        check("clr_cyc", cycle_cnt, 0);

        // Match on the edge that would also hit the timeout.
        timeout_lim = 5; addr_in = 32'h10;
        arm_once();
        tick(4);
        check("col_pre", cycle_cnt, 4);
        addr_in = END_ADDR;
        tick(1);
        check("col_done", done, 1'b1);
        check("col_tout", timeout, 1'b0);
        check("col_cyc", cycle_cnt, 4);

        // Asynchronous reset in the middle of a run.
        timeout_lim = 0; addr_in = 32'h10;
        arm_once();
        tick(7);
        check("mid_cyc7", cycle_cnt, 7);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", busy, 1'b0);
        check("async_cyc", cycle_cnt, 0);
        check("async_state", dbg_state, IDLE);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_state", dbg_state, IDLE);
        check("post_rst_cyc", cycle_cnt, 0);

        // Saturation on the narrow instance: 20 cycles of evt 0, then match.
        s_arm = 1'b1;
        tick(1);
        s_arm = 1'b0; s_evt = 2'b01;
        tick(20);
        check("sat_run_cyc", s_cyc, 4'd15);
        check("sat_run_busy", s_busy, 1'b1);
        s_addr = END_ADDR;
        tick(1);
        check("sat_done", s_done, 1'b1);
        check("sat_tout", s_timeout, 1'b0);
        check("sat_cyc", s_cyc, 4'd15);
        check("sat_evt", s_evt_cnt, 8'h0f);
        check("sat_state", s_state, DONE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Synthesizable run-control and performance monitor for the pipeline CPU. It is armed by the bench or a debug master and counts clock cycles until the observed PC reaches a programmable end address. It also counts up to N_EVT per-cycle event strobes (stalls, flushes, branch taken, ...), and aborts on a programmable timeout. It sits beside `top`, snooping the PC output and pipeline event lines, so cycle counts are available in gate-level simulation and silicon without a behavioural loop.

## Interface
- WIDTH_I, 32, PC width
- CNT_W, 32, width of every counter
- N_EVT, 4, number of event channels (≥1)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- addr_in  in  WIDTH_I  PC being observed
- end_addr  in  WIDTH_I  termination PC, sampled every cycle
- timeout_lim  in  CNT_W  cycle limit; 0 disables timeout
- evt_in  in  N_EVT  per-cycle event strobes
- arm  in  1  start a measurement (level sampled per edge)
- clr  in  1  abort and zero everything
- cycle_cnt  out  CNT_W  counted cycles
- evt_cnt  out  N_EVT*CNT_W  channel k at [k*CNT_W +: CNT_W]
- busy  out  1  measurement running
- done  out  1  end address reached
- timeout  out  1  limit reached before end address

## Operation
- States: IDLE, RUN, DONE, TOUT. busy/done/timeout are decoded from the state register only; there is no combinational path from inputs.
- IDLE: arm=1 → RUN. All counters are zeroed on the same edge.
- RUN, at each edge, evaluated in priority order:
  - clr=1 → IDLE, counters zeroed.
  - addr_in==end_addr → DONE. Counters are not incremented on this edge.
  - Otherwise cycle_cnt+1, and evt_cnt[k]+1 for each evt_in[k]=1. If timeout_lim≠0 and the new cycle_cnt equals timeout_lim → TOUT.
- DONE/TOUT: counters hold.
  - arm=1 → RUN with counters zeroed (re-arm).
  - clr=1 → IDLE with counters zeroed.
- arm while in RUN is ignored. clr wins over arm in every state.
- All counters saturate at 2^CNT_W−1 and never wrap. Saturation of cycle_cnt does not by itself end RUN.
- A match takes priority over timeout on the same edge.
- Changing end_addr or timeout_lim during RUN takes effect on the next edge.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE; cycle_cnt=0, evt_cnt=0, busy=0, done=0, timeout=0 immediately, without waiting for a clock edge. This applies mid-RUN as well.
- Release of rst_n is synchronous to clk by the surrounding logic; the block takes no action on release.
- The edge that samples arm=1 sets busy=1 after that edge. The first counted sample is the following edge.
- Latency: done/timeout rise one clock after the deciding edge's inputs, i.e. they are valid right after that edge. busy falls on the same edge.
- cycle_cnt equals the number of RUN edges on which addr_in≠end_addr. A program whose PC steps through K distinct non-end addresses, one per cycle, reports K.

## Structure
- Shared package perf_pkg:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2, TOUT=2'd3);
  - default CNT_W, WIDTH_I, N_EVT;
  - end-of-program address constant 32'h0000_0080, used by benches.
- Sub-module perf_sat_counter (parameter CNT_W; ports clk, rst_n, clr_i, inc_i, cnt_o): a saturating up-counter with synchronous clear. It is instantiated once for cycle_cnt and N_EVT times via generate for evt_cnt.
- The FSM and compare logic live in perf_monitor. Estimated size: ~200 lines total.

## Test plan
- Reset: assert rst_n=0 mid-RUN at cycle_cnt=7, between edges → all outputs 0 within the same time step. After release, state stays IDLE with no arm.
- Nominal run: end_addr=0x80, timeout_lim=0, arm one cycle, then addr_in=0x00,0x04,…,0x7C,0x80 one per cycle → done=1, busy=0, cycle_cnt=32, timeout=0; values hold for 5 further cycles.
- Timeout: timeout_lim=10, addr_in fixed 0x10, end_addr=0x80 → timeout=1 after the 10th counted edge, cycle_cnt=10, done=0.
- Match vs timeout collision: timeout_lim=5; addr_in reaches end_addr on the edge where the count would become 5 → done=1, timeout=0, cycle_cnt=4.
- Events and saturation: CNT_W=4, N_EVT=2, evt_in=2'b01 for 20 cycles, then match → evt_cnt[0]=15, evt_cnt[1]=0, cycle_cnt=15, done=1.
- Control collisions:
  - arm=1 and clr=1 on the same edge in DONE → IDLE, all counters 0.
  - arm pulsed during RUN → counts unaffected.
  - re-arm from TOUT → counters restart from 0.
